up_down_counter_mod: RTL



---
 rtl/up_down_counter_pkg.sv | 9 +
 rtl/udc_next_val.sv | 56 +++++
 rtl/up_down_counter_mod.sv | 91 +++++++++
 3 files changed

// File: rtl/up_down_counter_pkg.sv
// Shared direction and mode encodings for the up/down counter family.
package up_down_counter_pkg;

    localparam logic UP        = 1'b1;
    localparam logic DOWN      = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/udc_next_val.sv
// Next-count arithmetic for an in-range count: adds or subtracts the effective
// step inside the range 0..max_val and reports carry/borrow.
module udc_next_val
    import up_down_counter_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic [CNT_WIDTH:0]   step_i,
    input  logic [CNT_WIDTH:0]   range_i,
    input  logic [CNT_WIDTH-1:0] max_val_i,
    input  logic                 up_down_i,
    input  logic                 sat_mode_i,
    output logic [CNT_WIDTH-1:0] next_o,
    output logic                 carry_o,
    output logic                 borrow_o
);

    logic [CNT_WIDTH:0] cnt_ext;
    logic [CNT_WIDTH:0] max_ext;
    logic [CNT_WIDTH:0] sum;
    logic [CNT_WIDTH:0] wrap_up;
    logic [CNT_WIDTH:0] diff;
    logic [CNT_WIDTH:0] wrap_dn;

    // One extra bit keeps cnt + s and cnt + R - s free of overflow even when
    // max_val is all-ones and R = 2^CNT_WIDTH.
    assign cnt_ext = {1'b0, cnt_i};
    assign max_ext = {1'b0, max_val_i};
    assign sum     = cnt_ext + step_i;
    assign wrap_up = sum - range_i;
    assign diff    = cnt_ext - step_i;
    assign wrap_dn = cnt_ext + range_i - step_i;

    always_comb begin
        next_o   = cnt_i;
        carry_o  = 1'b0;
        borrow_o = 1'b0;
        if (up_down_i == UP) begin
            if (sum > max_ext) begin
                carry_o = 1'b1;
                next_o  = (sat_mode_i == MODE_SAT) ? max_val_i : CNT_WIDTH'(wrap_up);
            end else begin
                next_o = CNT_WIDTH'(sum);
            end
        end else begin
            if (cnt_ext >= step_i) begin
                next_o = CNT_WIDTH'(diff);
            end else begin
                borrow_o = 1'b1;
                next_o   = (sat_mode_i == MODE_SAT) ? '0 : CNT_WIDTH'(wrap_dn);
            end
        end
    end

endmodule

// File: rtl/up_down_counter_mod.sv
// Programmable-modulus up/down counter with variable step, wrap/saturate mode,
// registered carry/borrow pulses and combinational at_max/at_min decode.
module up_down_counter_mod
    import up_down_counter_pkg::*;
#(
    parameter int CNT_WIDTH  = 8,
    parameter int STEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [CNT_WIDTH-1:0]  counter_in,
    input  logic                  up_down,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [CNT_WIDTH-1:0]  max_val,
    input  logic                  sat_mode,
    output logic [CNT_WIDTH-1:0]  counter_out,
    output logic                  carry_out,
    output logic                  borrow_out,
    output logic                  at_max,
    output logic                  at_min
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 carry_q, carry_d;
    logic                 borrow_q, borrow_d;

    logic [CNT_WIDTH:0]   range_w;
    logic [CNT_WIDTH:0]   step_ext;
    logic [CNT_WIDTH:0]   step_eff;
    logic [CNT_WIDTH-1:0] next_val;
    logic                 next_carry;
    logic                 next_borrow;

    assign range_w  = {1'b0, max_val} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign step_ext = {{(CNT_WIDTH + 1 - STEP_WIDTH){1'b0}}, step};
    // A step larger than the range is clamped to R, i.e. a full lap.
    assign step_eff = (step_ext < range_w) ? step_ext : range_w;

    udc_next_val #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_next_val (
        .cnt_i      (cnt_q),
        .step_i     (step_eff),
        .range_i    (range_w),
        .max_val_i  (max_val),
        .up_down_i  (up_down),
        .sat_mode_i (sat_mode),
        .next_o     (next_val),
        .carry_o    (next_carry),
        .borrow_o   (next_borrow)
    );

    always_comb begin
        cnt_d    = cnt_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (load) begin
            cnt_d = (counter_in > max_val) ? max_val : counter_in;
        end else if (enable) begin
            // max_val may have shrunk below the count: snap back into range first.
            if (cnt_q > max_val) begin
                cnt_d = (sat_mode == MODE_SAT) ? max_val : '0;
            end else if (step != '0) begin
                cnt_d    = next_val;
                carry_d  = next_carry;
                borrow_d = next_borrow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign counter_out = cnt_q;
    assign carry_out   = carry_q;
    assign borrow_out  = borrow_q;
    assign at_max      = (cnt_q == max_val);
    assign at_min      = (cnt_q == '0);

endmodule
